// File: rtl/find_edges_scan.sv
// Scans outward from a centre pixel in four directions (right, left, down, up) and
// reports the last pixel of each run of matching pixels, bridging gaps shorter than GAP_TOL.
module find_edges_scan #(
  parameter int                 WIDTH        = 240,
  parameter int                 HEIGHT       = 320,
  parameter int                 PIXEL_W      = 16,
  parameter logic [PIXEL_W-1:0] MATCH_VAL    = 16'h00FF,
  parameter logic [PIXEL_W-1:0] MATCH_MASK   = 16'hFFFF,
  parameter int                 GAP_TOL      = 4,
  parameter int                 READ_LATENCY = 2,
  localparam int                XW           = $clog2(WIDTH),
  localparam int                YW           = $clog2(HEIGHT),
  localparam int                AW           = $clog2(WIDTH * HEIGHT)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start_in,
  input  logic [XW-1:0]      x_center,
  input  logic [YW-1:0]      y_center,
  input  logic [PIXEL_W-1:0] pixel_data_in,
  output logic [AW-1:0]      addr_out,
  output logic               rd_en_out,
  output logic               busy_out,
  output logic               edges_valid_out,
  output logic [XW-1:0]      right_edge,
  output logic [XW-1:0]      left_edge,
  output logic [YW-1:0]      bot_edge,
  output logic [YW-1:0]      top_edge,
  output logic [3:0]         found_out,
  output logic               range_err_out
);

  localparam int CW = (XW > YW) ? XW : YW;
  localparam int MW = $clog2(GAP_TOL + 1);

  typedef enum logic [2:0] {IDLE, SCAN_R, SCAN_L, SCAN_D, SCAN_U, DONE} state_t;

  state_t          state;
  logic [XW-1:0]   xc;
  logic [YW-1:0]   yc;
  logic [AW-1:0]   c_addr;
  logic [CW-1:0]   iss_crd;
  logic            hit;
  logic [CW-1:0]   last_hit;
  logic [MW-1:0]   miss;
  logic [CW-1:0]   res_edge [4];
  logic [3:0]      res_found;

  // Tag pipeline aligned with the BRAM: the last stage describes pixel_data_in.
  logic            pipe_vld [READ_LATENCY];
  logic [1:0]      pipe_dir [READ_LATENCY];
  logic [CW-1:0]   pipe_crd [READ_LATENCY];
  logic            pipe_brd [READ_LATENCY];

  logic [1:0]      dir;
  logic            in_scan;
  logic            iss_border;
  logic            ret_ok;
  logic            match;
  logic            hit_now;
  logic [CW-1:0]   last_now;
  logic [MW-1:0]   miss_inc;
  logic            term;
  logic [CW-1:0]   center_crd;
  logic [CW-1:0]   edge_val;
  logic [3:0]      found_upd;
  logic [AW-1:0]   step;
  logic            x_bad;
  logic            y_bad;
  logic [AW-1:0]   start_addr;

  always_comb begin
    dir     = 2'd0;
    in_scan = 1'b1;
    case (state)
      SCAN_R:  dir = 2'd0;
      SCAN_L:  dir = 2'd1;
      SCAN_D:  dir = 2'd2;
      SCAN_U:  dir = 2'd3;
      default: in_scan = 1'b0;
    endcase
  end

  always_comb begin
    iss_border = 1'b0;
    case (dir)
      2'd0: iss_border = (iss_crd == CW'(WIDTH - 1));
      2'd1: iss_border = (iss_crd == '0);
      2'd2: iss_border = (iss_crd == CW'(HEIGHT - 1));
      2'd3: iss_border = (iss_crd == '0);
      default: iss_border = 1'b0;
    endcase
  end

  assign ret_ok     = in_scan && pipe_vld[READ_LATENCY-1] && (pipe_dir[READ_LATENCY-1] == dir);
  assign match      = ((pixel_data_in & MATCH_MASK) == (MATCH_VAL & MATCH_MASK));
  assign hit_now    = hit | match;
  assign last_now   = match ? pipe_crd[READ_LATENCY-1] : last_hit;
  assign miss_inc   = miss + MW'(1);
  assign term       = ret_ok && (pipe_brd[READ_LATENCY-1] || (!match && (miss_inc == MW'(GAP_TOL))));
  assign center_crd = dir[1] ? CW'(yc) : CW'(xc);
  assign edge_val   = hit_now ? last_now : center_crd;
  assign step       = dir[1] ? AW'(WIDTH) : AW'(1);
  assign x_bad      = (32'(x_center) >= WIDTH);
  assign y_bad      = (32'(y_center) >= HEIGHT);
  assign start_addr = AW'(y_center) * AW'(WIDTH) + AW'(x_center);

  always_comb begin
    found_upd      = res_found;
    found_upd[dir] = hit_now;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      xc              <= '0;
      yc              <= '0;
      c_addr          <= '0;
      iss_crd         <= '0;
      hit             <= 1'b0;
      last_hit        <= '0;
      miss            <= '0;
      res_found       <= '0;
      addr_out        <= '0;
      rd_en_out       <= 1'b0;
      busy_out        <= 1'b0;
      edges_valid_out <= 1'b0;
      range_err_out   <= 1'b0;
      right_edge      <= '0;
      left_edge       <= '0;
      bot_edge        <= '0;
      top_edge        <= '0;
      found_out       <= '0;
      for (int i = 0; i < 4; i++) res_edge[i] <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_dir[i] <= '0;
        pipe_crd[i] <= '0;
        pipe_brd[i] <= 1'b0;
      end
    end else begin
      edges_valid_out <= 1'b0;
      range_err_out   <= 1'b0;

      pipe_vld[0] <= rd_en_out && in_scan;
      pipe_dir[0] <= dir;
      pipe_crd[0] <= iss_crd;
      pipe_brd[0] <= iss_border;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dir[i] <= pipe_dir[i-1];
        pipe_crd[i] <= pipe_crd[i-1];
        pipe_brd[i] <= pipe_brd[i-1];
      end

      case (state)
        IDLE: begin
          if (start_in) begin
            if (x_bad || y_bad) begin
              range_err_out   <= 1'b1;
              edges_valid_out <= 1'b1;
              right_edge      <= x_bad ? XW'(WIDTH - 1) : x_center;
              left_edge       <= x_bad ? XW'(WIDTH - 1) : x_center;
              bot_edge        <= y_bad ? YW'(HEIGHT - 1) : y_center;
              top_edge        <= y_bad ? YW'(HEIGHT - 1) : y_center;
              found_out       <= '0;
            end else begin
              xc        <= x_center;
              yc        <= y_center;
              c_addr    <= start_addr;
              addr_out  <= start_addr;
              iss_crd   <= CW'(x_center);
              rd_en_out <= 1'b1;
              busy_out  <= 1'b1;
              hit       <= 1'b0;
              miss      <= '0;
              last_hit  <= '0;
              state     <= SCAN_R;
            end
          end
        end

        SCAN_R, SCAN_L, SCAN_D, SCAN_U: begin
          if (term) begin
            res_edge[dir] <= edge_val;
            res_found     <= found_upd;
            hit           <= 1'b0;
            miss          <= '0;
            if (state == SCAN_U) begin
              right_edge      <= res_edge[0][XW-1:0];
              left_edge       <= res_edge[1][XW-1:0];
              bot_edge        <= res_edge[2][YW-1:0];
              top_edge        <= edge_val[YW-1:0];
              found_out       <= found_upd;
              edges_valid_out <= 1'b1;
              rd_en_out       <= 1'b0;
              state           <= DONE;
            end else begin
              // Every direction restarts at the centre pixel.
              rd_en_out <= 1'b1;
              addr_out  <= c_addr;
              iss_crd   <= (state == SCAN_R) ? CW'(xc) : CW'(yc);
              state     <= (state == SCAN_R) ? SCAN_L : (state == SCAN_L) ? SCAN_D : SCAN_U;
            end
          end else begin
            if (ret_ok) begin
              if (match) begin
                hit      <= 1'b1;
                last_hit <= pipe_crd[READ_LATENCY-1];
                miss     <= '0;
              end else begin
                miss <= miss_inc;
              end
            end
            if (rd_en_out) begin
              if (iss_border) begin
                rd_en_out <= 1'b0;
              end else begin
                addr_out <= dir[0] ? addr_out - step : addr_out + step;
                iss_crd  <= dir[0] ? iss_crd - CW'(1) : iss_crd + CW'(1);
              end
            end
          end
        end

        DONE: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_find_edges_scan.sv
// Directed bench for find_edges_scan: a procedural frame (rectangle with optional row hole)
// served through a two-stage read pipeline.
module tb_find_edges_scan;
  localparam int WIDTH = 240;
  localparam int HEIGHT = 320;
  localparam int PW = 16;
  localparam int XW = 8;
  localparam int YW = 9;
  localparam int AW = 17;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          start_in = 1'b0;
  logic [XW-1:0] x_center = '0;
  logic [YW-1:0] y_center = '0;
  logic [PW-1:0] pixel_data_in;
  logic [AW-1:0] addr_out;
  logic          rd_en_out, busy_out, edges_valid_out, range_err_out;
  logic [XW-1:0] right_edge, left_edge;
  logic [YW-1:0] bot_edge, top_edge;
  logic [3:0]    found_out;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  find_edges_scan #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIXEL_W(PW), .MATCH_VAL(16'h00FF), .MATCH_MASK(16'hFFFF),
    .GAP_TOL(4), .READ_LATENCY(2)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .x_center(x_center), .y_center(y_center), .pixel_data_in(pixel_data_in),
    .addr_out(addr_out), .rd_en_out(rd_en_out), .busy_out(busy_out),
    .edges_valid_out(edges_valid_out), .right_edge(right_edge), .left_edge(left_edge),
    .bot_edge(bot_edge), .top_edge(top_edge), .found_out(found_out), .range_err_out(range_err_out)
  );

  // Scene: rectangle [rx0..rx1]x[ry0..ry1], minus a hole hx0..hx1 on row hy.
  int rx0 = 100, rx1 = 149, ry0 = 200, ry1 = 259;
  int hx0 = 0, hx1 = -1, hy = -1;

  function automatic logic [PW-1:0] pix(int a);
    int x, y;
    x = a % WIDTH;
    y = a / WIDTH;
    if (x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1 && !(y == hy && x >= hx0 && x <= hx1))
      return 16'h00FF;
    return 16'h10FF;
  endfunction

  logic [PW-1:0] rd_s0 = '0, rd_s1 = '0;
  always @(posedge clk_in) begin
    rd_s0 <= rd_en_out ? pix(int'(addr_out)) : 16'h0000;
    rd_s1 <= rd_s0;
  end
  assign pixel_data_in = rd_s1;

  int valid_cnt = 0, rd_cnt = 0, bad_cnt = 0, watch_cnt = 0;
  logic [AW-1:0] bad_addr = '1;
  logic [AW-1:0] watch_addr = '1;
  always @(negedge clk_in) begin
    if (edges_valid_out) valid_cnt++;
    if (rd_en_out) begin
      rd_cnt++;
      if (addr_out == bad_addr || int'(addr_out) >= WIDTH * HEIGHT) bad_cnt++;
      if (addr_out == watch_addr) watch_cnt++;
    end
  end

  int   r_cycles;
  logic r_got, r_busy_ok;

  task automatic run_scan(input int x, input int y, input bit poke);
    @(posedge clk_in); #1;
    x_center = XW'(x);
    y_center = YW'(y);
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    r_cycles = 0;
    r_busy_ok = 1'b1;
    while (!edges_valid_out && r_cycles < 4000) begin
      if (!busy_out) r_busy_ok = 1'b0;
      start_in = poke && (r_cycles == 30);
      if (start_in) begin
        x_center = 8'd10;
        y_center = 9'd10;
      end
      @(posedge clk_in); #1;
      r_cycles++;
    end
    start_in = 1'b0;
    r_got = edges_valid_out;
    $display("scan (%0d,%0d) valid=%0d cycles=%0d r=%0d l=%0d b=%0d t=%0d found=%b",
             x, y, r_got, r_cycles, right_edge, left_edge, bot_edge, top_edge, found_out);
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if ({rd_en_out, busy_out, edges_valid_out, range_err_out, found_out, addr_out} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got rd=%b busy=%b v=%b err=%b found=%b addr=%0d want all 0",
               rd_en_out, busy_out, edges_valid_out, range_err_out, found_out, addr_out);
    end
    checks++;
    if ({right_edge, left_edge, bot_edge, top_edge} !== '0) begin
      failures++;
      $display("FAIL reset_edges got %0d %0d %0d %0d want 0", right_edge, left_edge, bot_edge, top_edge);
    end
    rst_n_in = 1'b1;
    $display("reset released");
  endtask

  task automatic test_basic();
    int v0;
    rx0 = 100; rx1 = 149; ry0 = 200; ry1 = 259; hy = -1;
    watch_addr = AW'(230 * WIDTH + 120);
    watch_cnt = 0;
    v0 = valid_cnt;
    run_scan(120, 230, 1'b0);
    checks++;
    if (r_got !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b want=1", r_got); end
    checks++;
    if (r_busy_ok !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", r_busy_ok); end
    checks++;
    if (right_edge !== 8'd149) begin failures++; $display("FAIL basic_right got=%0d want=149", right_edge); end
    checks++;
    if (left_edge !== 8'd100) begin failures++; $display("FAIL basic_left got=%0d want=100", left_edge); end
    checks++;
    if (bot_edge !== 9'd259) begin failures++; $display("FAIL basic_bot got=%0d want=259", bot_edge); end
    checks++;
    if (top_edge !== 9'd200) begin failures++; $display("FAIL basic_top got=%0d want=200", top_edge); end
    checks++;
    if (found_out !== 4'b1111) begin failures++; $display("FAIL basic_found got=%b want=1111", found_out); end
    @(posedge clk_in); #1;
    checks++;
    if ({edges_valid_out, busy_out} !== 2'b00) begin
      failures++;
      $display("FAIL basic_after got valid=%b busy=%b want 0 0", edges_valid_out, busy_out);
    end
    checks++;
    if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL basic_pulses got=%0d want=1", valid_cnt - v0); end
    checks++;
    if (watch_cnt !== 4) begin failures++; $display("FAIL basic_centre_reads got=%0d want=4", watch_cnt); end
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if (right_edge !== 8'd149) begin failures++; $display("FAIL basic_hold got=%0d want=149", right_edge); end
  endtask

  task automatic test_gap();
    hy = 230; hx0 = 130; hx1 = 132;
    run_scan(120, 230, 1'b0);
    checks++;
    if ({r_got, right_edge, left_edge, found_out} !== {1'b1, 8'd149, 8'd100, 4'b1111}) begin
      failures++;
      $display("FAIL gap3 got valid=%b r=%0d l=%0d found=%b want 1 149 100 1111",
               r_got, right_edge, left_edge, found_out);
    end
    hx1 = 133;
    run_scan(120, 230, 1'b0);
    checks++;
    if ({r_got, right_edge, left_edge, bot_edge, top_edge} !== {1'b1, 8'd129, 8'd100, 9'd259, 9'd200}) begin
      failures++;
      $display("FAIL gap4 got valid=%b r=%0d l=%0d b=%0d t=%0d want 1 129 100 259 200",
               r_got, right_edge, left_edge, bot_edge, top_edge);
    end
    hy = -1;
  endtask

  task automatic test_range();
    int r0;
    r0 = rd_cnt;
    @(posedge clk_in); #1;
    x_center = 8'd240;
    y_center = 9'd5;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    $display("range (240,5) err=%b valid=%b r=%0d l=%0d b=%0d t=%0d",
             range_err_out, edges_valid_out, right_edge, left_edge, bot_edge, top_edge);
    checks++;
    if ({range_err_out, edges_valid_out, busy_out} !== 3'b110) begin
      failures++;
      $display("FAIL range_pulse got err=%b valid=%b busy=%b want 1 1 0", range_err_out, edges_valid_out, busy_out);
    end
    checks++;
    if ({right_edge, left_edge, bot_edge, top_edge, found_out} !== {8'd239, 8'd239, 9'd5, 9'd5, 4'b0000}) begin
      failures++;
      $display("FAIL range_edges got r=%0d l=%0d b=%0d t=%0d found=%b want 239 239 5 5 0000",
               right_edge, left_edge, bot_edge, top_edge, found_out);
    end
    @(posedge clk_in); #1;
    checks++;
    if ({range_err_out, edges_valid_out} !== 2'b00) begin
      failures++;
      $display("FAIL range_one_cycle got err=%b valid=%b want 0 0", range_err_out, edges_valid_out);
    end
    repeat (4) @(posedge clk_in);
    #1;
    checks++;
    if (rd_cnt !== r0) begin failures++; $display("FAIL range_no_reads got=%0d want=%0d", rd_cnt, r0); end
  endtask

  task automatic test_border();
    rx0 = 200; rx1 = 239; ry0 = 200; ry1 = 259; hy = -1;
    bad_addr = AW'(231 * WIDTH);
    bad_cnt = 0;
    watch_addr = AW'(230 * WIDTH + 239);
    watch_cnt = 0;
    run_scan(220, 230, 1'b0);
    checks++;
    if ({r_got, right_edge, left_edge, bot_edge, top_edge} !== {1'b1, 8'd239, 8'd200, 9'd259, 9'd200}) begin
      failures++;
      $display("FAIL border_edges got valid=%b r=%0d l=%0d b=%0d t=%0d want 1 239 200 259 200",
               r_got, right_edge, left_edge, bot_edge, top_edge);
    end
    checks++;
    if (bad_cnt !== 0) begin failures++; $display("FAIL border_wrap got=%0d want=0", bad_cnt); end
    checks++;
    if (watch_cnt !== 1) begin failures++; $display("FAIL border_last_read got=%0d want=1", watch_cnt); end
    bad_addr = '1;
  endtask

  task automatic test_empty();
    rx0 = 1000; rx1 = 0;
    run_scan(10, 10, 1'b0);
    checks++;
    if ({r_got, found_out} !== {1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL empty_found got valid=%b found=%b want 1 0000", r_got, found_out);
    end
    checks++;
    if ({right_edge, left_edge, bot_edge, top_edge} !== {8'd10, 8'd10, 9'd10, 9'd10}) begin
      failures++;
      $display("FAIL empty_edges got r=%0d l=%0d b=%0d t=%0d want 10 10 10 10",
               right_edge, left_edge, bot_edge, top_edge);
    end
  endtask

  task automatic test_reset_mid();
    int v0, n, r0;
    logic seen;
    rx0 = 100; rx1 = 149; ry0 = 200; ry1 = 259; hy = -1;
    @(posedge clk_in); #1;
    x_center = 8'd120;
    y_center = 9'd230;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      seen = rd_en_out && (addr_out == AW'(233 * WIDTH + 120));
      if (!seen) begin
        @(posedge clk_in); #1;
        n++;
      end
    end
    checks++;
    if (seen !== 1'b1) begin failures++; $display("FAIL mid_reach_down got=%b want=1", seen); end
    v0 = valid_cnt;
    #2;
    rst_n_in = 1'b0;
    #1;
    $display("reset asserted during down scan");
    checks++;
    if ({rd_en_out, busy_out, edges_valid_out, addr_out, right_edge, left_edge, bot_edge, top_edge, found_out} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got rd=%b busy=%b v=%b addr=%0d r=%0d l=%0d b=%0d t=%0d f=%b want 0",
               rd_en_out, busy_out, edges_valid_out, addr_out, right_edge, left_edge, bot_edge, top_edge, found_out);
    end
    repeat (4) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    repeat (6) @(posedge clk_in);
    #1;
    checks++;
    if ({valid_cnt - v0, 1'b0} !== {32'd0, busy_out}) begin
      failures++;
      $display("FAIL mid_no_pulse got pulses=%0d busy=%b want 0 0", valid_cnt - v0, busy_out);
    end
    run_scan(120, 230, 1'b1);
    checks++;
    if ({r_got, right_edge, left_edge, bot_edge, top_edge, found_out} !==
        {1'b1, 8'd149, 8'd100, 9'd259, 9'd200, 4'b1111}) begin
      failures++;
      $display("FAIL mid_fresh got valid=%b r=%0d l=%0d b=%0d t=%0d f=%b want 1 149 100 259 200 1111",
               r_got, right_edge, left_edge, bot_edge, top_edge, found_out);
    end
    @(posedge clk_in); #1;
    r0 = rd_cnt;
    repeat (5) @(posedge clk_in);
    #1;
    checks++;
    if ({busy_out, rd_cnt - r0} !== {1'b0, 32'd0}) begin
      failures++;
      $display("FAIL busy_start_ignored got busy=%b reads=%0d want 0 0", busy_out, rd_cnt - r0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_range();
    test_border();
    test_empty();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/find_edges_scan.md
Name: find_edges_scan

Overview:
- Parametrised successor to the frame-buffer corner finder: measures the extent of a thresholded object around a centre point.
- Scans outward from (x_center, y_center) in four directions: right, left, down, up.
- Reports the last matching pixel coordinate per direction, with gap tolerance and per-direction found flags.
- Sits between the tracking logic that supplies the centre and the frame-buffer BRAM read port; results feed the bounding-box overlay.

Parameters:
WIDTH, 240, frame width in pixels
HEIGHT, 320, frame height in pixels
PIXEL_W, 16, pixel data width
MATCH_VAL, 16'h00FF, pixel value counted as object
MATCH_MASK, 16'hFFFF, bits compared against MATCH_VAL
GAP_TOL, 4, consecutive non-matching pixels that end a direction (>=1)
READ_LATENCY, 2, cycles from addr_out/rd_en_out to pixel_data_in (>=1)

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
start_in  in  1  start request, sampled only when idle
x_center  in  $clog2(WIDTH)  centre column
y_center  in  $clog2(HEIGHT)  centre row
pixel_data_in  in  PIXEL_W  BRAM read data, READ_LATENCY cycles after the read
addr_out  out  $clog2(WIDTH*HEIGHT)  BRAM address, y*WIDTH+x
rd_en_out  out  1  addr_out valid this cycle
busy_out  out  1  scan in progress
edges_valid_out  out  1  one-cycle pulse; edge outputs and found_out updated
right_edge, left_edge  out  $clog2(WIDTH)  x of last match right/left of centre
bot_edge, top_edge  out  $clog2(HEIGHT)  y of last match below/above centre
found_out  out  4  {up,down,left,right}: at least one match in that direction
range_err_out  out  1  one-cycle pulse; centre out of frame

Behaviour:
- Reset (async assert, sync release): all outputs 0 and FSM in IDLE. In-flight returns are discarded. A reset mid-scan produces no edges_valid pulse.
- States: IDLE -> SCAN_R -> SCAN_L -> SCAN_D -> SCAN_U -> DONE -> IDLE.
- Start:
  - start_in in IDLE latches the centre and enters SCAN_R; busy_out rises next cycle.
  - start_in while busy is ignored, not queued.
- Range check: if x_center>=WIDTH or y_center>=HEIGHT at start:
  - No reads are issued.
  - Next cycle: range_err_out and edges_valid_out pulse together.
  - Edges are set to the clamped centre; found_out=0; return to IDLE.
- Issue:
  - Each scan state issues one read per cycle (rd_en_out=1), starting at the centre pixel.
  - Step per cycle: +1 (R), -1 (L), +WIDTH (D), -WIDTH (U).
  - Issuing stops after the border pixel (x=WIDTH-1, x=0, y=HEIGHT-1, y=0) or at termination.
  - Each read carries a coordinate and direction tag through a READ_LATENCY-deep pipeline.
- Process (each returned pixel whose tag matches the current direction):
  - match = (pixel & MATCH_MASK) == (MATCH_VAL & MATCH_MASK).
  - On match: last_hit <= coordinate, hit flag set, miss counter cleared.
  - Otherwise the miss counter increments.
- Termination: the direction ends on the cycle the miss counter reaches GAP_TOL, or when the border pixel's return is processed.
  - That direction's edge register <= last_hit if hit, else the centre coordinate.
  - found_out bit <= hit flag.
  - The next direction issues its first read the following cycle.
  - Stale returns carrying the old tag are discarded.
- The centre pixel is included in every direction, so it is read four times.
- DONE: one-cycle edges_valid_out pulse. All four edges and found_out are stable from that cycle until the next pulse. Then IDLE with busy_out=0.
- Edge outputs update only in a DONE or range-error cycle; they hold otherwise.
- Worst-case latency per direction: span + READ_LATENCY + 1 cycles.
- Corner cases:
  - A centre on a border terminates that direction after one return.
  - Matches beyond a gap of length >= GAP_TOL are ignored. Gaps shorter than GAP_TOL are bridged.

Test Plan:
- READ_LATENCY=2, GAP_TOL=4; object = rectangle x 100..149, y 200..259; start with centre (120,230) -> one edges_valid pulse; right=149, left=100, bot=259, top=200; found=4'b1111; busy high throughout.
- Same object with a 3-pixel hole at x 130..132 on row 230 -> right_edge=149 (gap bridged). Widen the hole to 4 pixels (x 130..133) -> right_edge=129.
- Object reaching x=239 at the centre row -> right_edge=239. The right scan issues its last read at x=239 and never addresses x=240; no address wrap.
- Centre pixel and neighbours non-matching, centre (10,10) -> found=4'b0000; all edges equal the centre (10,10).
- Centre (240,5) -> range_err_out and edges_valid_out pulse the cycle after start; rd_en_out never asserts.
- Assert rst_n_in low mid SCAN_D -> outputs 0 immediately, no valid pulse. A fresh start after release gives correct results. A start_in pulsed during busy has no effect.
